// File: rtl/aes_pkg.sv
// Shared AES-192 definitions: FSM state type, round counts and byte-level
// transforms. Inverse transforms exist only when AES_DECRYPT_EN is defined.
package aes_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_EXPAND, ST_ENC, ST_DEC, ST_FIN} state_e;

  localparam int NUM_ROUNDS192 = 12;
  localparam int ROUND_KEYS192 = 13;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] r;
    s = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] a;
    a = gf_inv(x);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^
           {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(b[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[127-8*(row+4*col) -: 8] = b[127-8*(row+4*((col+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] b);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127-32*c -: 8];
      a1 = b[119-32*c -: 8];
      a2 = b[111-32*c -: 8];
      a3 = b[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

`ifdef AES_DECRYPT_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_sbox(b[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[127-8*(row+4*col) -: 8] = b[127-8*(row+4*((col-row+4)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] b);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127-32*c -: 8];
      a1 = b[119-32*c -: 8];
      a2 = b[111-32*c -: 8];
      a3 = b[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/aes_round.sv
// Combinational single AES round. Forward: SubBytes, ShiftRows, MixColumns
// (skipped when last), AddRoundKey. Inverse (only with AES_DECRYPT_EN):
// InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (skipped when last).
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] block,
  input  logic [127:0] key,
  input  logic         inv,
  input  logic         last,
  output logic [127:0] result
);

  logic [127:0] fwd_sr;
  logic [127:0] fwd_out;

  // Forward round
  always_comb begin
    fwd_sr  = shift_rows(sub_bytes(block));
    fwd_out = (last ? fwd_sr : mix_columns(fwd_sr)) ^ key;
  end

`ifdef AES_DECRYPT_EN
  logic [127:0] inv_ark;
  logic [127:0] inv_out;

  // Inverse round and direction select
  always_comb begin
    inv_ark = inv_sub_bytes(inv_shift_rows(block)) ^ key;
    inv_out = last ? inv_ark : inv_mix_columns(inv_ark);
    result  = inv ? inv_out : fwd_out;
  end
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign result     = fwd_out;
`endif

endmodule

// File: rtl/aes192_cipher.sv
// Iterative AES-192 cipher, one round per cycle with round keys streamed in
// from an external key expander. Decryption (EXPAND/DEC states, inverse
// datapath, done1/predone/done2) is built only when AES_DECRYPT_EN is defined.
module aes192_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] inBlock,
  input  logic [127:0] roundKey,
  output logic         expReset,
  output logic         done1,
  output logic         predone,
  output logic         done2,
  output logic [127:0] outBlock,
  output logic         valid,
  output logic         busy
);

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS192);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] out_q, out_d;
  logic         done2_q, done2_d;
  logic         dec_req;
  logic         rnd_inv, rnd_last;
  logic [127:0] rnd_out;
  logic [127:0] step_out;

`ifdef AES_DECRYPT_EN
  assign dec_req = decrypt;
`else
  assign dec_req = 1'b0;
`endif

  assign rnd_inv  = (state_q == ST_DEC);
  assign rnd_last = (cnt_q == LAST_CNT);

  aes_round u_round (
    .block  (blk_q),
    .key    (roundKey),
    .inv    (rnd_inv),
    .last   (rnd_last),
    .result (rnd_out)
  );

  // Count 0 is a bare AddRoundKey in both directions
  assign step_out = (cnt_q == 4'd0) ? (blk_q ^ roundKey) : rnd_out;

  // Next-state, round counter and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    out_d   = out_q;
    done2_d = done2_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          blk_d   = inBlock;
          cnt_d   = 4'd0;
          done2_d = 1'b0;
          state_d = dec_req ? ST_EXPAND : ST_ENC;
        end
      end
`ifdef AES_DECRYPT_EN
      ST_EXPAND: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 4'd0;
          state_d = ST_DEC;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DEC: begin
        blk_d = step_out;
        if (cnt_q == LAST_CNT) begin
          out_d   = step_out;
          done2_d = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      ST_ENC: begin
        blk_d = step_out;
        if (cnt_q == LAST_CNT) begin
          out_d   = step_out;
          cnt_d   = 4'd0;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_FIN: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and result registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      out_q   <= '0;
      done2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done2_q <= done2_d;
    end
  end

  // Working state block; only meaningful while an operation is running
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
  end

  assign expReset = (state_q == ST_IDLE) && start;
  assign busy     = (state_q != ST_IDLE);
  assign valid    = (state_q == ST_FIN);
  assign outBlock = out_q;

`ifdef AES_DECRYPT_EN
  assign done1   = (state_q == ST_DEC);
  assign predone = (state_q == ST_EXPAND) && (cnt_q == LAST_CNT);
  assign done2   = done2_q;
`else
  logic unused_ok;
  assign unused_ok = decrypt ^ done2_q;
  assign done1     = 1'b0;
  assign predone   = 1'b0;
  assign done2     = 1'b0;
`endif

endmodule

// File: tb/tb_aes192_cipher.sv
// Scoreboard bench for aes192_cipher with a behavioural AES-192 key expander.
// Decrypt scenarios are exercised when AES_DECRYPT_EN is defined; otherwise
// the bench expects decrypt requests to run as encrypts.
module tb_aes192_cipher;

  localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         decrypt;
  logic [127:0] inBlock;
  logic [127:0] roundKey;
  logic         expReset, done1, predone, done2, valid, busy;
  logic [127:0] outBlock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int c0     = 0;
  int kidx   = 0;
  int rst_cyc;

  typedef struct {
    logic [127:0] blk;
    int           cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  logic [127:0] rk[13];

  aes192_cipher dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .decrypt  (decrypt),
    .inBlock  (inBlock),
    .roundKey (roundKey),
    .expReset (expReset),
    .done1    (done1),
    .predone  (predone),
    .done2    (done2),
    .outBlock (outBlock),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference key schedule ----------------
  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = tb_xt(p);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] iv;
    logic [7:0] r;
    logic [7:0] c;
    iv = 8'h00;
    c  = 8'h63;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (tb_mul(x, 8'(y)) == 8'h01) iv = 8'(y);
    for (int i = 0; i < 8; i++)
      r[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
    return r;
  endfunction

  function automatic logic [31:0] tb_subword(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  task automatic build_keys();
    logic [31:0]  w[52];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [191:0] k;
    k  = KEY;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t  = tb_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Behavioural key expander: restart, forward, hold at predone, reverse, freeze
  always @(posedge clk or posedge reset) begin
    if (reset)             kidx <= 0;
    else if (expReset)     kidx <= 0;
    else if (done2)        kidx <= kidx;
    else if (done1)        kidx <= (kidx > 0) ? kidx - 1 : 0;
    else if (predone)      kidx <= kidx;
    else if (kidx < 12)    kidx <= kidx + 1;
  end

  always_comb roundKey = rk[kidx];

  // Output monitor: every valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 128'(valid), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("outBlock", outBlock, e.blk);
        chk("valid_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic start_op(input logic [127:0] blk, input logic dec);
    @(posedge clk);
    #1;
    start   = 1'b1;
    decrypt = dec;
    inBlock = blk;
    c0      = cyc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    decrypt = 1'b0;
    inBlock = '0;
    build_keys();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outBlock", outBlock, 128'(0));
    chk("rst_valid",    128'(valid),    128'(0));
    chk("rst_busy",     128'(busy),     128'(0));
    chk("rst_expReset", 128'(expReset), 128'(0));
    chk("rst_done1",    128'(done1),    128'(0));
    chk("rst_done2",    128'(done2),    128'(0));
    chk("rst_predone",  128'(predone),  128'(0));
    next_cycle();
    reset = 1'b0;

    // FIPS-197 C.2 encrypt
    start_op(PT, 1'b0);
    sb.push_back('{CT, c0 + 14});
    @(negedge clk);
    chk("expReset_accept", 128'(expReset), 128'(1));
    chk("busy_in_idle",    128'(busy),     128'(0));
    next_cycle();
    start = 1'b0;
    chk("busy_running", 128'(busy), 128'(1));
    drain(40);
    repeat (3) next_cycle();
    chk("outBlock_hold", outBlock, CT);
    chk("busy_after",    128'(busy), 128'(0));

`ifdef AES_DECRYPT_EN
    // FIPS-197 C.2 decrypt with expander handshake timing
    start_op(CT, 1'b1);
    sb.push_back('{PT, c0 + 27});
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      chk("predone", 128'(predone), 128'(n == 13));
      chk("done1",   128'(done1),   128'(n >= 14 && n <= 26));
      chk("done2",   128'(done2),   128'(n >= 27));
      next_cycle();
      start = 1'b0;
    end
    drain(10);
    rst_cyc = 20;
`else
    // Decrypt request must run as an encrypt with expander flags low
    start_op(PT, 1'b1);
    sb.push_back('{CT, c0 + 14});
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk);
      chk("no_predone", 128'(predone), 128'(0));
      chk("no_done1",   128'(done1),   128'(0));
      chk("no_done2",   128'(done2),   128'(0));
      next_cycle();
      start = 1'b0;
    end
    drain(10);
    rst_cyc = 7;
`endif

    // Start while busy is ignored
    start_op(PT, 1'b0);
    sb.push_back('{CT, c0 + 14});
    next_cycle();
    start = 1'b0;
    repeat (4) next_cycle();
    start   = 1'b1;
    inBlock = CT;
    next_cycle();
    start = 1'b0;
    drain(30);
    repeat (20) next_cycle();

    // Reset in the middle of an operation
`ifdef AES_DECRYPT_EN
    start_op(CT, 1'b1);
`else
    start_op(CT, 1'b0);
`endif
    next_cycle();
    start = 1'b0;
    repeat (rst_cyc - 1) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_outBlock", outBlock, 128'(0));
    chk("midrst_busy",     128'(busy),    128'(0));
    chk("midrst_valid",    128'(valid),   128'(0));
    chk("midrst_done1",    128'(done1),   128'(0));
    chk("midrst_done2",    128'(done2),   128'(0));
    chk("midrst_predone",  128'(predone), 128'(0));
    repeat (2) next_cycle();
    reset = 1'b0;
    repeat (35) next_cycle();
    start_op(PT, 1'b0);
    sb.push_back('{CT, c0 + 14});
    next_cycle();
    start = 1'b0;
    drain(40);

    // Back-to-back encrypts with start held high
    start_op(PT, 1'b0);
    for (int k = 0; k < 4; k++) sb.push_back('{CT, c0 + 14 + 15*k});
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      chk("b2b_expReset", 128'(expReset), 128'(n % 15 == 0));
      chk("b2b_overlap",  128'(valid & expReset), 128'(0));
      next_cycle();
    end
    start = 1'b0;
    drain(30);
    repeat (20) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes192_cipher.md
AES192_CIPHER -- requirements
Module: aes192_cipher

Interface
- REQ-001 clk  in  1  system clock; all state updates on its rising edge.
- REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
- REQ-003 start  in  1  request; sampled only in IDLE.
- REQ-004 decrypt  in  1  mode; sampled together with start: 0 = encrypt, 1 = decrypt.
- REQ-005 inBlock  in  128  plaintext or ciphertext; sampled together with start.
- REQ-006 roundKey  in  128  round key from the key expander, one key per cycle.
- REQ-007 expReset  out  1  single-cycle restart pulse to the key expander.
- REQ-008 done1, predone, done2  out  1 each  expander control: reverse-expansion enable, last-forward-step flag, freeze.
- REQ-009 outBlock  out  128  result; holds its value until the next accepted start.
- REQ-010 valid  out  1  single-cycle pulse marking a new outBlock.
- REQ-011 busy  out  1  high in every state except IDLE.

Function
- REQ-012 States are IDLE, EXPAND, ENC, DEC and FIN.
- REQ-013 Transitions are as follows:
  - IDLE goes to ENC on start & !decrypt.
  - IDLE goes to EXPAND on start & decrypt.
  - EXPAND goes to DEC after 13 cycles.
  - ENC and DEC each go to FIN after 13 cycles.
  - FIN goes to IDLE after one cycle.
- REQ-014 In the start-accept cycle, expReset = 1, and inBlock and mode are registered.
- REQ-015 A 4-bit round counter runs 0..12 in EXPAND, ENC and DEC, and clears on every state change.
- REQ-016 ENC consumes rk0..rk12 in counter order:
  - count 0: AddRoundKey only;
  - counts 1..11: SubBytes, ShiftRows, MixColumns, AddRoundKey;
  - count 12: same without MixColumns.
- REQ-017 EXPAND leaves the datapath idle while the expander runs forward.
- REQ-018 predone = 1 only at EXPAND count 12.
- REQ-019 DEC holds done1 = 1 and consumes rk12..rk0:
  - count 0: AddRoundKey;
  - counts 1..11: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns;
  - count 12: same without InvMixColumns.
- REQ-020 outBlock is loaded on the edge that leaves ENC or DEC, and valid = 1 in FIN only.
- REQ-021 Latency from the start cycle to valid is 14 cycles for encrypt and 27 cycles for decrypt.
- REQ-022 done2 = 1 from FIN after a decrypt until the next accepted start.
- REQ-023 start asserted while busy is ignored; there is no queueing.
- REQ-024 start in the same cycle as FIN is ignored, because acceptance happens only in IDLE.
- REQ-025 expReset, done1 and predone are 0 in every state not named above.

Reset
- REQ-026 On reset the block enters IDLE with the counter at 0.
- REQ-027 On reset, outBlock, valid, busy, done1, done2, predone and expReset are all 0.
- REQ-028 A reset mid-operation abandons the operation: no valid pulse, and outBlock = 0.

Configuration
- REQ-029 Macro AES_DECRYPT_EN defined: the EXPAND and DEC states and the inverse datapath are present, behaving as described above.
- REQ-030 Macro AES_DECRYPT_EN undefined, the decrypt input is ignored:
  - every start performs an encrypt;
  - done1, predone and done2 are tied to 0;
  - no inverse S-box or InvMixColumns logic is synthesised.

Structure
- REQ-031 Shared package aes_pkg holds:
  - the state enum type;
  - NUM_ROUNDS192 = 12;
  - ROUND_KEYS192 = 13.
- REQ-032 One sub-module, aes_round: a combinational single round with inputs block, key, inv and last.

Verification
- REQ-033 FIPS-197 C.2 encrypt:
  - stimulus: key 000102030405060708090a0b0c0d0e0f1011121314151617, inBlock 00112233445566778899aabbccddeeff, decrypt = 0;
  - required response: valid at cycle 14 with outBlock dda97ca4864cdfe06eaf70a0ec0d7191.
- REQ-034 FIPS-197 C.2 decrypt:
  - stimulus: same key, inBlock dda97ca4864cdfe06eaf70a0ec0d7191, decrypt = 1;
  - required response: predone at cycle 13, done1 high over cycles 14..26, valid at cycle 27 with outBlock 00112233445566778899aabbccddeeff, done2 held high afterwards.
- REQ-035 Start while busy:
  - stimulus: a second start at cycle 5 of an encrypt;
  - required response: ignored, exactly one valid pulse, at cycle 14.
- REQ-036 Mid-operation reset:
  - stimulus: reset at DEC count 6;
  - required response: outputs 0 immediately, no valid pulse; a following encrypt still meets REQ-033.
- REQ-037 Back-to-back operations:
  - stimulus: start held high continuously;
  - required response: encrypts complete every 15 cycles, with valid and expReset never asserted in the same cycle.
